// File: rtl/router_rx_port.sv
// Router receive port: reassembles 4-byte serial packets into 32-bit words
// and queues them for the crossbar. Checker guarded by ROUTER_RX_PROTOCOL_CHECK_EN.
module router_rx_port #(
   parameter int PORTID = 0,
   parameter int DEPTH  = 2
) (
   input  logic        clock,
   input  logic        reset,
   output logic        free_out,
   input  logic        put_in,
   input  logic [7:0]  payload_in,
   output logic [31:0] pkt_out,
   output logic [3:0]  pkt_dest,
   output logic        pkt_valid,
   input  logic        pkt_ready,
   output logic [3:0]  count,
   output logic        proto_err
);

   localparam int              PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      LDEPTH = 4'(DEPTH);
   localparam logic [PW-1:0]   LAST   = PW'(DEPTH - 1);

   if (DEPTH < 1 || DEPTH > 8 || PORTID < 0 || PORTID > 15) begin : g_bad_param
      $error("router_rx_port: illegal DEPTH or PORTID");
   end

   typedef enum logic {IDLE, RECV} state_t;

   state_t        r_state;
   logic [1:0]    r_ptr;
   logic [31:0]   r_asm;
   logic [31:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [3:0]    r_count;
   logic [31:0]   r_head;

   logic          w_room;
   logic          w_start;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_word;
   logic [PW-1:0] w_wnext;
   logic [PW-1:0] w_rnext;

   assign w_room  = (r_count < LDEPTH);
   assign w_start = (r_state == IDLE) && put_in && w_room;
   assign w_push  = (r_state == RECV) && put_in && (r_ptr == 2'd3);
   assign w_pop   = (r_count != 4'd0) && pkt_ready;
   assign w_word  = {r_asm[31:8], payload_in};
   assign w_wnext = (r_wptr == LAST) ? '0 : r_wptr + 1'b1;
   assign w_rnext = (r_rptr == LAST) ? '0 : r_rptr + 1'b1;

   assign free_out  = (r_state == IDLE) && !put_in && w_room;
   assign pkt_out   = r_head;
   assign pkt_dest  = r_head[27:24];
   assign pkt_valid = (r_count != 4'd0);
   assign count     = r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= 2'd0;
         r_asm   <= 32'd0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_asm[31:24] <= payload_in;
                  r_ptr        <= 2'd1;
                  r_state      <= RECV;
               end
            end
            RECV: begin
               if (put_in) begin
                  unique case (r_ptr)
                     2'd0: r_asm[31:24] <= payload_in;
                     2'd1: r_asm[23:16] <= payload_in;
                     2'd2: r_asm[15:8]  <= payload_in;
                     2'd3: r_asm[7:0]   <= payload_in;
                  endcase
                  if (r_ptr == 2'd3) begin
                     r_ptr   <= 2'd0;
                     r_state <= IDLE;
                  end else begin
                     r_ptr <= r_ptr + 2'd1;
                  end
               end else begin
                  r_ptr   <= 2'd0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ptr   <= 2'd0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= w_word;
   end

   // Head register: refill from storage when more remain, else take the new word.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= 4'd0;
         r_head  <= 32'd0;
      end else begin
         if (w_push) r_wptr <= w_wnext;
         if (w_pop)  r_rptr <= w_rnext;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 4'd1;
            2'b01:   r_count <= r_count - 4'd1;
            default: r_count <= r_count;
         endcase
         if (w_pop && (r_count > 4'd1))
            r_head <= r_mem[w_rnext];
         else if (w_push && ((r_count == 4'd0) || w_pop))
            r_head <= w_word;
      end
   end

`ifdef ROUTER_RX_PROTOCOL_CHECK_EN
   localparam logic [3:0] LPORT = 4'(PORTID);

   logic r_err;
   logic w_trunc;
   logic w_illegal;
   logic w_badsrc;

   assign w_trunc   = (r_state == RECV) && !put_in;
   assign w_illegal = (r_state == IDLE) && put_in && (r_count == LDEPTH);
   assign w_badsrc  = w_push && (w_word[31:28] != LPORT);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_err <= 1'b0;
      else if (w_trunc || w_illegal || w_badsrc)
         r_err <= 1'b1;
   end

   assign proto_err = r_err;
`else
   assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_rx_port.sv
// Self-checking bench for router_rx_port: directed scenarios then random
// byte traffic, compared against a queue-based packet model.
module tb_router_rx_port;

   localparam int PORTID = 1;
   localparam int DEPTH  = 2;

   logic        clock;
   logic        reset;
   logic        free_out;
   logic        put_in;
   logic [7:0]  payload_in;
   logic [31:0] pkt_out;
   logic [3:0]  pkt_dest;
   logic        pkt_valid;
   logic        pkt_ready;
   logic [3:0]  count;
   logic        proto_err;

   router_rx_port #(.PORTID(PORTID), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .free_out   (free_out),
      .put_in     (put_in),
      .payload_in (payload_in),
      .pkt_out    (pkt_out),
      .pkt_dest   (pkt_dest),
      .pkt_valid  (pkt_valid),
      .pkt_ready  (pkt_ready),
      .count      (count),
      .proto_err  (proto_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mq[$];
   logic [7:0]  mb[$];
   bit          m_rx;
   bit          m_err;
   logic [31:0] m_out;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_err();
`ifdef ROUTER_RX_PROTOCOL_CHECK_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk_outs();
      chk("pkt_valid", 32'(pkt_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("pkt_out", pkt_out, m_out);
      chk("pkt_dest", 32'(pkt_dest), 32'(m_out[27:24]));
      chk("proto_err", 32'(proto_err), 32'(exp_err()));
   endtask

   task automatic step(input bit put, input logic [7:0] b, input bit rdy);
      bit          efree;
      int          sz;
      logic [31:0] w;
      @(negedge clock);
      put_in     = put;
      payload_in = b;
      pkt_ready  = rdy;
      #1;
      sz    = mq.size();
      efree = !m_rx && !put && (sz < DEPTH);
      chk("free_out", 32'(free_out), 32'(efree));
      if (sz != 0 && rdy) void'(mq.pop_front());
      if (m_rx) begin
         if (put) begin
            mb.push_back(b);
            if (mb.size() == 4) begin
               w = {mb[0], mb[1], mb[2], mb[3]};
               mq.push_back(w);
               if (w[31:28] != 4'(PORTID)) m_err = 1'b1;
               mb.delete();
               m_rx = 1'b0;
            end
         end else begin
            mb.delete();
            m_rx  = 1'b0;
            m_err = 1'b1;
         end
      end else if (put) begin
         if (sz < DEPTH) begin
            mb.delete();
            mb.push_back(b);
            m_rx = 1'b1;
         end else begin
            m_err = 1'b1;
         end
      end
      if (mq.size() != 0) m_out = mq[0];
      @(posedge clock);
      #1;
      chk_outs();
   endtask

   task automatic send(input logic [31:0] w, input bit rdy_last);
      step(1'b1, w[31:24], 1'b0);
      step(1'b1, w[23:16], 1'b0);
      step(1'b1, w[15:8],  1'b0);
      step(1'b1, w[7:0],   rdy_last);
   endtask

   task automatic do_reset();
      @(negedge clock);
      put_in    = 1'b0;
      pkt_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      mq.delete();
      mb.delete();
      m_rx  = 1'b0;
      m_err = 1'b0;
      m_out = 32'd0;
      chk_outs();
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("free_after_reset", 32'(free_out), 32'd1);
   endtask

   initial begin
      reset      = 1'b0;
      put_in     = 1'b0;
      payload_in = 8'd0;
      pkt_ready  = 1'b0;
      m_rx       = 1'b0;
      m_err      = 1'b0;
      m_out      = 32'd0;
      do_reset();

      // single packet
      send(32'h12345678, 1'b0);
      chk("single_out", pkt_out, 32'h12345678);
      chk("single_dest", 32'(pkt_dest), 32'd2);
      step(1'b0, 8'h00, 1'b1);

      // fill and stall
      send(32'h1A000001, 1'b0);
      send(32'h1B000002, 1'b0);
      chk("fill_count", 32'(count), 32'd2);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      chk("stall_head", pkt_out, 32'h1B000002);
      step(1'b0, 8'h00, 1'b0);

      // push and pop on the same edge with one entry queued
      send(32'h1C0000C3, 1'b1);
      chk("pushpop_count", 32'(count), 32'd1);
      chk("pushpop_head", pkt_out, 32'h1C0000C3);
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);

      // truncation
      step(1'b1, 8'h15, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b0, 8'h00, 1'b0);
      send(32'h15AABBCC, 1'b0);
      chk("trunc_next", pkt_out, 32'h15AABBCC);
      step(1'b0, 8'h00, 1'b0);

      // illegal start while full
      send(32'h1D00D00D, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
      chk("illegal_count", 32'(count), 32'd2);

      // reset mid-packet with a packet queued
      step(1'b0, 8'h00, 1'b1);
      step(1'b1, 8'h1E, 1'b0);
      step(1'b1, 8'h01, 1'b0);
      step(1'b1, 8'h02, 1'b0);
      do_reset();
      send(32'h17654321, 1'b0);
      step(1'b0, 8'h00, 1'b1);

      // bad source still stored
      send(32'h3F000001, 1'b0);
      chk("badsrc_out", pkt_out, 32'h3F000001);
      step(1'b0, 8'h00, 1'b1);

      do_reset();
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 9) < 8, 8'($urandom),
              $urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
